// File: rtl/core_run_ctrl.sv
// core_run_ctrl: run/halt/step sequencer for the rv32i core with breakpoint halt,
// plus register-file port arbitration that hands the port to the debugger while halted.
module core_run_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter bit RESET_RUN      = 1'b0
) (
    input  logic                      CLK,
    input  logic                      RSTn,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [DATA_WIDTH-1:0]     cmd_arg,
    output logic                      cmd_err,
    output logic                      cpu_stop,
    input  logic                      core_retire,
    input  logic [DATA_WIDTH-1:0]     core_next_pc,
    input  logic                      bp_enable,
    input  logic [DATA_WIDTH-1:0]     bp_addr,
    output logic                      halted,
    output logic [1:0]                halt_cause,
    output logic [DATA_WIDTH-1:0]     retired_count,
    input  logic                      dbg_req,
    input  logic                      dbg_we,
    input  logic [REG_ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0]     dbg_wdata,
    output logic [DATA_WIDTH-1:0]     dbg_rdata,
    output logic                      dbg_ack,
    output logic                      dbg_err,
    input  logic [REG_ADDR_WIDTH-1:0] cpu_rf_addr,
    input  logic                      cpu_rf_we,
    input  logic [DATA_WIDTH-1:0]     cpu_rf_wdata,
    output logic [REG_ADDR_WIDTH-1:0] rf_addr,
    output logic                      rf_we,
    output logic [DATA_WIDTH-1:0]     rf_wdata,
    input  logic [DATA_WIDTH-1:0]     rf_rdata
);
    typedef enum logic [2:0] {HALTED, RUN, STEP, DBG_ISSUE, DBG_RESP} state_t;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;
    localparam logic [1:0] OP_STEP  = 2'b11;
    state_t                  state, state_n;
    logic [DATA_WIDTH-1:0]   step_cnt, step_cnt_n;
    logic [1:0]              cause_n;
    logic                    run, issue, acc, retire, bp_hit, step_done, host_stop, halt;
    logic                    start, step_ok, cmd_err_n, dbg_ack_n, dbg_err_n, early_req;
    assign run       = state == RUN || state == STEP;
    assign issue     = state == DBG_ISSUE;
    assign cpu_stop  = !run;
    assign halted    = !run;
    assign cmd_ready = run || (state == HALTED && !dbg_req);
    assign rf_addr   = issue ? dbg_addr : cpu_rf_addr;
    assign rf_wdata  = issue ? dbg_wdata : cpu_rf_wdata;
    assign rf_we     = issue ? dbg_we && dbg_addr != '0 : cpu_rf_we && run;
    always_comb begin
        acc       = cmd_valid && cmd_ready;
        retire    = core_retire && run;
        bp_hit    = retire && bp_enable && core_next_pc == bp_addr;
        step_done = retire && state == STEP && step_cnt == DATA_WIDTH'(1);
        host_stop = acc && cmd_op == OP_STOP && run;
        halt      = host_stop || bp_hit || step_done;
        start     = acc && cmd_op == OP_START && state != RUN;
        step_ok   = acc && cmd_op == OP_STEP && state == HALTED && cmd_arg != '0;
        cmd_err_n = acc && cmd_op == OP_STEP && !step_ok;
        // a request seen while running is refused; skip the cycle right after any ack
        early_req = run && dbg_req && !dbg_ack;
        dbg_ack_n = issue || early_req;
        dbg_err_n = issue ? dbg_we && dbg_addr == '0 : early_req;
        state_n   = halt ? HALTED
                  : (state == HALTED && dbg_req && !dbg_ack) ? DBG_ISSUE
                  : start ? RUN
                  : step_ok ? STEP
                  : issue ? DBG_RESP
                  : state == DBG_RESP ? HALTED
                  : state;
        cause_n   = host_stop ? 2'b01 : bp_hit ? 2'b11 : step_done ? 2'b10
                  : (start || step_ok) ? 2'b00 : halt_cause;
        step_cnt_n = step_ok ? cmd_arg
                   : (retire && state == STEP) ? step_cnt - DATA_WIDTH'(1)
                   : step_cnt;
    end
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state         <= RESET_RUN ? RUN : HALTED;
            halt_cause    <= 2'b00;
            retired_count <= '0;
            step_cnt      <= '0;
            cmd_err       <= 1'b0;
            dbg_ack       <= 1'b0;
            dbg_err       <= 1'b0;
            dbg_rdata     <= '0;
        end else begin
            state         <= state_n;
            halt_cause    <= cause_n;
            retired_count <= retired_count + DATA_WIDTH'(retire);
            step_cnt      <= step_cnt_n;
            cmd_err       <= cmd_err_n;
            dbg_ack       <= dbg_ack_n;
            dbg_err       <= dbg_err_n;
            dbg_rdata     <= issue ? rf_rdata : dbg_rdata;
        end
    end
endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl: directed run/step/breakpoint/debug scenarios followed by random
// command and retire traffic, all checked against a cycle-level behavioural model.
module tb_core_run_ctrl;
    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_err, cpu_stop, halted;
    logic [1:0]  cmd_op = 2'b00, halt_cause;
    logic [31:0] cmd_arg = '0, core_next_pc = '0, bp_addr = '0, retired_count;
    logic        core_retire = 1'b0, bp_enable = 1'b0;
    logic        dbg_req = 1'b0, dbg_we = 1'b0, dbg_ack, dbg_err;
    logic [4:0]  dbg_addr = '0, cpu_rf_addr = '0, rf_addr;
    logic [31:0] dbg_wdata = '0, dbg_rdata, cpu_rf_wdata = '0, rf_wdata, rf_rdata;
    logic        cpu_rf_we = 1'b0, rf_we;
    logic [31:0] rf_mem [32];
    int unsigned total = 0, bad = 0;
    // reference model: running flag, remaining step budget (0 = free run), debug phase
    bit          m_run = 1'b0, m_err = 1'b0;
    int          m_dbg = 0;
    logic [1:0]  m_cause = 2'b00;
    logic [31:0] m_left = '0, m_count = '0;

    core_run_ctrl dut (
        .CLK(CLK), .RSTn(RSTn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .cmd_err(cmd_err), .cpu_stop(cpu_stop), .core_retire(core_retire),
        .core_next_pc(core_next_pc), .bp_enable(bp_enable), .bp_addr(bp_addr),
        .halted(halted), .halt_cause(halt_cause), .retired_count(retired_count),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack), .dbg_err(dbg_err),
        .cpu_rf_addr(cpu_rf_addr), .cpu_rf_we(cpu_rf_we), .cpu_rf_wdata(cpu_rf_wdata),
        .rf_addr(rf_addr), .rf_we(rf_we), .rf_wdata(rf_wdata), .rf_rdata(rf_rdata)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) if (rf_we && rf_addr != 5'd0) rf_mem[rf_addr] <= rf_wdata;
    assign rf_rdata = (rf_addr == 5'd0) ? 32'd0 : rf_mem[rf_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit stop, bp, sd, err;
        err = 1'b0;
        if (m_run) begin
            stop = cmd_valid && cmd_op == 2'b10;
            bp   = core_retire && bp_enable && core_next_pc == bp_addr;
            sd   = core_retire && m_left == 32'd1;
            err  = cmd_valid && cmd_op == 2'b11;
            if (core_retire) begin
                m_count = m_count + 32'd1;
                if (m_left != 0) m_left = m_left - 32'd1;
            end
            if (stop || bp || sd) begin
                m_run = 1'b0;
                m_cause = stop ? 2'b01 : bp ? 2'b11 : 2'b10;
            end else if (cmd_valid && cmd_op == 2'b01) begin
                m_left = '0;
                m_cause = 2'b00;
            end
        end else if (m_dbg > 0) m_dbg--;
        else if (dbg_req) m_dbg = 2;
        else if (cmd_valid && cmd_op == 2'b01) begin
            m_run = 1'b1; m_left = '0; m_cause = 2'b00;
        end else if (cmd_valid && cmd_op == 2'b11) begin
            if (cmd_arg != 0) begin
                m_run = 1'b1; m_left = cmd_arg; m_cause = 2'b00;
            end else err = 1'b1;
        end
        m_err = err;
    endtask

    task automatic cyc();
        #1;
        chk("cmd_ready", 32'(cmd_ready), 32'(m_run || (m_dbg == 0 && !dbg_req)));
        chk("rf_we", 32'(rf_we), 32'(m_dbg == 2 ? (dbg_we && dbg_addr != 5'd0) : (cpu_rf_we && m_run)));
        chk("rf_addr", 32'(rf_addr), 32'(m_dbg == 2 ? dbg_addr : cpu_rf_addr));
        model_edge();
        @(posedge CLK);
        #1;
        chk("cpu_stop", 32'(cpu_stop), 32'(!m_run));
        chk("halted", 32'(halted), 32'(!m_run));
        chk("halt_cause", 32'(halt_cause), 32'(m_cause));
        chk("retired_count", retired_count, m_count);
        chk("cmd_err", 32'(cmd_err), 32'(m_err));
    endtask

    task automatic cmd(input logic [1:0] op, input logic [31:0] arg);
        cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
        cyc();
        cmd_valid = 1'b0; cmd_op = 2'b00;
    endtask

    task automatic model_reset();
        m_run = 1'b0; m_err = 1'b0; m_dbg = 0; m_cause = 2'b00; m_left = '0; m_count = '0;
    endtask

    initial begin
        #1;
        chk("rst cpu_stop", 32'(cpu_stop), 32'd1);
        chk("rst halt_cause", 32'(halt_cause), 32'd0);
        chk("rst retired_count", retired_count, 32'd0);
        chk("rst dbg_ack", 32'(dbg_ack), 32'd0);
        chk("rst dbg_err", 32'(dbg_err), 32'd0);
        chk("rst dbg_rdata", dbg_rdata, 32'd0);
        chk("rst cmd_err", 32'(cmd_err), 32'd0);
        repeat (2) @(posedge CLK);
        #1 RSTn = 1'b1;
        // run, retire five, host stop
        cmd(2'b01, 0);
        chk("start cpu_stop", 32'(cpu_stop), 32'd0);
        for (int i = 0; i < 5; i++) begin
            core_retire = 1'b1; core_next_pc = 32'h100 + 32'(4 * i);
            cyc();
        end
        core_retire = 1'b0;
        chk("count5", retired_count, 32'd5);
        cmd(2'b10, 0);
        chk("stop cause", 32'(halt_cause), 32'd1);
        // single-step three instructions, then a rejected zero-length step
        cmd(2'b11, 32'd3);
        for (int i = 0; i < 6; i++) begin
            core_retire = (i % 2 == 0); core_next_pc = 32'h200 + 32'(4 * i);
            cyc();
        end
        core_retire = 1'b0;
        chk("step halted", 32'(cpu_stop), 32'd1);
        chk("step cause", 32'(halt_cause), 32'd2);
        chk("step count", retired_count, 32'd8);
        cmd(2'b11, 32'd0);
        chk("step0 err", 32'(cmd_err), 32'd1);
        cyc();
        chk("step0 err clear", 32'(cmd_err), 32'd0);
        // breakpoint at 0x40, then resume past it
        bp_enable = 1'b1; bp_addr = 32'h40;
        cmd(2'b01, 0);
        core_retire = 1'b1; core_next_pc = 32'h3c; cyc();
        core_next_pc = 32'h40; cyc();
        core_retire = 1'b0;
        chk("bp cause", 32'(halt_cause), 32'd3);
        chk("bp stop", 32'(cpu_stop), 32'd1);
        cmd(2'b01, 0);
        core_retire = 1'b1; core_next_pc = 32'h44; cyc();
        core_retire = 1'b0;
        chk("bp resume run", 32'(cpu_stop), 32'd0);
        cmd(2'b10, 0);
        // debug write then read of x5, with the CPU also presenting a write
        cpu_rf_we = 1'b1; cpu_rf_addr = 5'd7; cpu_rf_wdata = 32'h1234;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd5; dbg_wdata = 32'hdeadbeef;
        cyc();
        chk("wr issue ack", 32'(dbg_ack), 32'd0);
        chk("wr issue rf_wdata", rf_wdata, 32'hdeadbeef);
        cyc();
        chk("wr ack", 32'(dbg_ack), 32'd1);
        chk("wr err", 32'(dbg_err), 32'd0);
        dbg_req = 1'b0; dbg_we = 1'b0;
        cyc();
        chk("wr ack drop", 32'(dbg_ack), 32'd0);
        chk("x5 written", rf_mem[5], 32'hdeadbeef);
        dbg_req = 1'b1;
        cyc();
        chk("rd issue ack", 32'(dbg_ack), 32'd0);
        cyc();
        chk("rd ack", 32'(dbg_ack), 32'd1);
        chk("rd rdata", dbg_rdata, 32'hdeadbeef);
        chk("rd err", 32'(dbg_err), 32'd0);
        dbg_req = 1'b0;
        cyc();
        // write to x0 is dropped and flagged
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd0; dbg_wdata = 32'h55;
        cyc();
        cyc();
        chk("x0 ack", 32'(dbg_ack), 32'd1);
        chk("x0 err", 32'(dbg_err), 32'd1);
        dbg_req = 1'b0; dbg_we = 1'b0;
        cyc();
        // debug request while running is refused without touching the port
        cmd(2'b01, 0);
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd5; dbg_wdata = 32'hbad;
        cyc();
        chk("run req ack", 32'(dbg_ack), 32'd1);
        chk("run req err", 32'(dbg_err), 32'd1);
        cyc();
        chk("run req no reack", 32'(dbg_ack), 32'd0);
        dbg_req = 1'b0; dbg_we = 1'b0;
        chk("x5 kept", rf_mem[5], 32'hdeadbeef);
        cpu_rf_we = 1'b0;
        // host stop beats a same-cycle breakpoint
        core_retire = 1'b1; core_next_pc = 32'h40;
        cmd(2'b10, 0);
        core_retire = 1'b0;
        chk("stop over bp", 32'(halt_cause), 32'd1);
        // debug wins over a simultaneous command while halted
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5;
        cmd_valid = 1'b1; cmd_op = 2'b01;
        #1 chk("dbg prio ready", 32'(cmd_ready), 32'd0);
        cyc();
        cyc();
        chk("dbg prio ack", 32'(dbg_ack), 32'd1);
        chk("dbg prio rdata", dbg_rdata, 32'hdeadbeef);
        dbg_req = 1'b0;
        cyc();
        cyc();
        chk("start after dbg", 32'(cpu_stop), 32'd0);
        cmd_valid = 1'b0; cmd_op = 2'b00;
        // randomised traffic
        for (int i = 0; i < 400; i++) begin
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_op = 2'($urandom_range(0, 3));
            cmd_arg = $urandom_range(0, 4);
            core_retire = 1'($urandom_range(0, 1));
            bp_enable = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 2))
                0: core_next_pc = 32'h40;
                1: core_next_pc = 32'h44;
                default: core_next_pc = $urandom;
            endcase
            cyc();
        end
        cmd_valid = 1'b0; core_retire = 1'b0;
        // asynchronous reset with a debug access in flight
        cmd(2'b01, 0);
        core_retire = 1'b1; cyc(); cyc();
        core_retire = 1'b0;
        cmd(2'b10, 0);
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5;
        cyc();
        #2 RSTn = 1'b0;
        #1;
        chk("arst cpu_stop", 32'(cpu_stop), 32'd1);
        chk("arst count", retired_count, 32'd0);
        chk("arst cause", 32'(halt_cause), 32'd0);
        chk("arst ack", 32'(dbg_ack), 32'd0);
        @(posedge CLK);
        #1;
        chk("arst no ack", 32'(dbg_ack), 32'd0);
        dbg_req = 1'b0;
        RSTn = 1'b1;
        model_reset();
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
Run-control sequencer and register-file port arbiter for the rv32i single-cycle core. Takes start/stop/step commands from the AXI control slave and drives cpu_stop, the clock-enable gate for all core components except the register file. Halts on host request, step-count exhaustion or a PC breakpoint. While the core is halted, grants the debug requester exclusive access to the register-file port; at all other times the CPU owns that port.

Parameters:
DATA_WIDTH, 32, register and PC width
REG_ADDR_WIDTH, 5, register-file address width
RESET_RUN, 0, 1 = leave reset in RUN, 0 = leave reset in HALTED

Ports:
CLK  in  1  clock
RSTn  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&&ready
cmd_op  in  2  01 START, 10 STOP, 11 STEP, 00 NOP
cmd_arg  in  DATA_WIDTH  step count for STEP
cmd_err  out  1  one-cycle pulse: command rejected
cpu_stop  out  1  1 = core clock gated
core_retire  in  1  core retired an instruction this cycle
core_next_pc  in  DATA_WIDTH  PC after the retiring instruction
bp_enable  in  1  breakpoint enable
bp_addr  in  DATA_WIDTH  breakpoint PC
halted  out  1  state is HALTED, DBG_ISSUE or DBG_RESP
halt_cause  out  2  00 none, 01 host, 10 step, 11 breakpoint
retired_count  out  DATA_WIDTH  retired-instruction counter
dbg_req  in  1  debug regfile request; held until dbg_ack
dbg_we  in  1  debug write
dbg_addr  in  REG_ADDR_WIDTH  debug register index
dbg_wdata  in  DATA_WIDTH  debug write data
dbg_rdata  out  DATA_WIDTH  debug read data, valid with dbg_ack
dbg_ack  out  1  one-cycle completion
dbg_err  out  1  error qualifier, valid with dbg_ack
cpu_rf_addr  in  REG_ADDR_WIDTH  CPU write-port address
cpu_rf_we  in  1  CPU write enable
cpu_rf_wdata  in  DATA_WIDTH  CPU write data
rf_addr  out  REG_ADDR_WIDTH  to register file
rf_we  out  1  to register file
rf_wdata  out  DATA_WIDTH  to register file
rf_rdata  in  DATA_WIDTH  from register file, combinational read

Behaviour:
- States: HALTED, RUN, STEP, DBG_ISSUE, DBG_RESP.
- Reset state is RUN if RESET_RUN=1, else HALTED. Reset values: halt_cause=00, retired_count=0, step_cnt=0, dbg_ack=0, dbg_err=0, dbg_rdata=0, cmd_err=0.
- cpu_stop = 0 in RUN and STEP, 1 otherwise. It is decoded from registered state only, with no combinational path from inputs.
- cmd_ready = 1 in RUN and STEP. In HALTED, cmd_ready = !dbg_req (debug has priority). cmd_ready = 0 in DBG_ISSUE and DBG_RESP.
- START:
  - From HALTED or STEP: go to RUN and clear halt_cause to 00.
  - In RUN: no-op.
- STOP:
  - From RUN or STEP: go to HALTED with halt_cause=01.
  - In HALTED: no-op, halt_cause unchanged.
- STEP:
  - From HALTED with cmd_arg>0: step_cnt<=cmd_arg, go to STEP, clear halt_cause.
  - cmd_arg==0, or STEP issued in RUN/STEP: cmd_err pulses the next cycle and state is unchanged.
  - NOP: accepted, no effect.
- STEP state: each core_retire decrements step_cnt. A retire with step_cnt==1 goes to HALTED with cause 10.
- Breakpoint: in RUN/STEP, core_retire && bp_enable && core_next_pc==bp_addr goes to HALTED with cause 11. Because the check uses the next PC, resuming from a breakpoint executes the instruction at bp_addr.
- Same-cycle halt sources: all halt; cause priority is host STOP > breakpoint > step.
- retired_count increments on core_retire while cpu_stop==0 and wraps modulo 2^DATA_WIDTH.
- Debug access:
  - HALTED with dbg_req: go to DBG_ISSUE. In DBG_ISSUE, rf_addr=dbg_addr, rf_wdata=dbg_wdata, rf_we=dbg_we && dbg_addr!=0, and dbg_rdata<=rf_rdata.
  - DBG_ISSUE then goes to DBG_RESP, which drives dbg_ack=1 for one cycle, with dbg_err=1 iff the request was a write to x0. DBG_RESP then returns to HALTED.
  - Latency from req to ack is 2 cycles.
- dbg_req in RUN/STEP: dbg_ack=1 and dbg_err=1 the next cycle, with no regfile access. No new ack is issued in the cycle immediately after any ack.
- Regfile port outside DBG_ISSUE: rf_addr=cpu_rf_addr, rf_wdata=cpu_rf_wdata, rf_we=cpu_rf_we && !cpu_stop.
- Reset mid-operation: an asynchronous reset in any state forces the reset values immediately; a pending debug request receives no ack.

Test Plan:
- Reset with RESET_RUN=0, then START -> cpu_stop falls the next cycle; 5 retires give retired_count=5; STOP -> cpu_stop=1, halt_cause=01.
- STEP arg=3 with retire every other cycle -> HALTED after the 3rd retire, cause 10, retired_count +3; STEP arg=0 -> cmd_err pulse, still HALTED.
- bp_enable=1, bp_addr=0x40, RUN, retire with core_next_pc=0x40 -> halt next cycle, cause 11; START, then retire with next_pc=0x44 -> stays RUN.
- HALTED, debug write x5=0xDEADBEEF, then debug read x5 -> rf_we pulse in DBG_ISSUE, ack 2 cycles after req, rdata=0xDEADBEEF, err=0.
- Debug write x0 -> rf_we=0, ack with err=1; dbg_req while RUN -> ack+err next cycle, rf port stays on CPU.
- STOP and breakpoint retire in the same cycle -> cause 01; dbg_req and cmd_valid together in HALTED -> cmd_ready=0, debug served first.
